// File: rtl/mem_access_unit_pkg.sv
// Shared constants and FSM state type for the dataMemory initiator.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned MEM_DEPTH = 128;
    localparam int unsigned ERRCNT_W  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StResp
    } muState_e;

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    output logic [ERRCNT_W-1:0] count
);

    logic [ERRCNT_W-1:0] countQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countQ <= '0;
        end else if (inc && (countQ != '1)) begin
            countQ <= countQ + ERRCNT_W'(1);
        end
    end

    assign count = countQ;

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the dataMemory port with
// address range checking and a saturating out-of-range counter.
module mem_access_unit #(
    parameter int unsigned DATA_W    = mem_access_unit_pkg::DATA_W,
    parameter int unsigned ADDR_W    = mem_access_unit_pkg::ADDR_W,
    parameter int unsigned MEM_DEPTH = mem_access_unit_pkg::MEM_DEPTH,
    parameter int unsigned ERRCNT_W  = mem_access_unit_pkg::ERRCNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_write,
    output logic                mem_read,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [ERRCNT_W-1:0] err_count
);

    import mem_access_unit_pkg::*;

    localparam logic [ADDR_W-1:0] DepthLimit = ADDR_W'(MEM_DEPTH);

    muState_e          stateQ, stateD;
    logic [ADDR_W-1:0] memAddrQ;
    logic [DATA_W-1:0] memWdataQ;
    logic [DATA_W-1:0] rdataQ;
    logic              errQ;
    logic              accept;
    logic              outOfRange;

    assign accept     = req_valid && (stateQ == StIdle);
    assign outOfRange = req_addr >= DepthLimit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (req_valid) begin
                    if (outOfRange) begin
                        stateD = StResp;
                    end else if (req_write) begin
                        stateD = StWr;
                    end else begin
                        stateD = StRd;
                    end
                end
            end
            StRd:    stateD = StCap;
            StCap:   stateD = StResp;
            StWr:    stateD = StResp;
            StResp:  if (rsp_ready) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (stateQ)
            StIdle:      req_ready = 1'b1;
            StRd, StCap: mem_read  = 1'b1;
            StWr:        mem_write = 1'b1;
            StResp:      rsp_valid = 1'b1;
            default:     req_ready = 1'b0;
        endcase
    end

    // The address/data registers double as the request latch; an out-of-range
    // request never touches them so the memory bus keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memAddrQ  <= '0;
            memWdataQ <= '0;
            rdataQ    <= '0;
            errQ      <= 1'b0;
        end else begin
            if (accept) begin
                rdataQ <= '0;
                errQ   <= outOfRange;
                if (!outOfRange) begin
                    memAddrQ <= req_addr;
                    if (req_write) begin
                        memWdataQ <= req_wdata;
                    end
                end
            end
            // Sampling at the end of CAP suits both combinational and registered memories.
            if (stateQ == StCap) begin
                rdataQ <= mem_rdata;
            end
        end
    end

    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;
    assign rsp_rdata = rdataQ;
    assign rsp_err   = errQ;

    sat_counter #(
        .ERRCNT_W(ERRCNT_W)
    ) u_errCounter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (accept && outOfRange),
        .count(err_count)
    );

endmodule
